// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// spi_master : mode-0 SPI master, 8-bit MSB-first frames, burst under one ss
// Revision   : 1.0
// ============================================================================
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam int                 c_div_w    = $clog2(CLK_DIV);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_div_w-1:0] r_div_cnt, w_div_nxt;
  logic [2:0]         r_bit_cnt, w_bit_nxt;
  logic [7:0]         r_tx_sh, w_tx_nxt;
  logic [7:0]         r_rx_sh, w_rx_nxt;
  logic [7:0]         r_rdata, w_rdata_nxt;
  logic               r_sck, w_sck_nxt;
  logic               r_ss, w_ss_nxt;
  logic               r_mosi, w_mosi_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               w_div_end;
  logic               w_accept;

  assign w_div_end = (r_div_cnt == c_div_last);
  // r_done is high only in the first HOLD cycle, which is the burst window
  assign w_accept  = start && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && r_done));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rdata   <= '0;
      r_sck     <= 1'b0;
      r_ss      <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_tx_sh   <= w_tx_nxt;
      r_rx_sh   <= w_rx_nxt;
      r_rdata   <= w_rdata_nxt;
      r_sck     <= w_sck_nxt;
      r_ss      <= w_ss_nxt;
      r_mosi    <= w_mosi_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = w_div_end ? '0 : r_div_cnt + 1'b1;
    w_bit_nxt   = r_bit_cnt;
    w_tx_nxt    = r_tx_sh;
    w_rx_nxt    = r_rx_sh;
    w_rdata_nxt = r_rdata;
    w_sck_nxt   = r_sck;
    w_ss_nxt    = r_ss;
    w_mosi_nxt  = r_mosi;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_div_nxt = '0;
      end
      ST_SETUP: begin
        if (w_div_end) begin
          w_sck_nxt   = 1'b1;
          w_rx_nxt    = {r_rx_sh[6:0], miso};
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_div_end) begin
          if (!r_sck) begin
            w_sck_nxt = 1'b1;
            w_rx_nxt  = {r_rx_sh[6:0], miso};
          end else begin
            w_sck_nxt = 1'b0;
            w_bit_nxt = r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              w_rdata_nxt = r_rx_sh;
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              // mosi keeps the LSB after the last bit, so only shift mid-frame
              w_tx_nxt   = {r_tx_sh[6:0], 1'b0};
              w_mosi_nxt = r_tx_sh[6];
            end
          end
        end
      end
      ST_HOLD: begin
        if (w_div_end) begin
          w_ss_nxt    = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_div_end) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_accept) begin
      w_state_nxt = ST_SETUP;
      w_div_nxt   = '0;
      w_bit_nxt   = '0;
      w_tx_nxt    = tdata;
      w_mosi_nxt  = tdata[7];
      w_ss_nxt    = 1'b0;
      w_busy_nxt  = 1'b1;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign ss    = r_ss;
  assign sck   = r_sck;
  assign mosi  = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// tb_spi_master : self-checking bench for spi_master with a mode-0 slave model
// Revision      : 1.0
// ============================================================================
module tb_spi_master;

  localparam int D = 4;
  localparam int T = 10;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
    logic [7:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       busy, done, ss, sck, mosi, miso;
  logic [7:0] rdata;

  logic       rst2 = 1'b1, start2 = 1'b0;
  logic [7:0] tdata2 = 8'h00;
  logic       busy2, done2, ss2, sck2, mosi2;
  logic [7:0] rdata2;

  int checks = 0;
  int errors = 0;
  logic [7:0] slv_tx_q[$];
  logic [7:0] exp_rdata_q[$];
  logic [7:0] exp_mosi_q[$];
  int  done_cnt = 0, ss_rise_cnt = 0, sck_rise_cnt = 0;
  time sck2_rise_t[$];

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .tdata(tdata), .busy(busy), .done(done),
    .rdata(rdata), .ss(ss), .sck(sck), .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .tdata(tdata2), .busy(busy2), .done(done2),
    .rdata(rdata2), .ss(ss2), .sck(sck2), .mosi(mosi2), .miso(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Mode-0 slave: shifts out on falling sck, captures mosi on rising sck
  logic [7:0] s_sh = 8'h00, s_rx = 8'h00;
  int         s_cnt = 0;
  assign miso = s_sh[7];

  function automatic logic [7:0] slv_peek();
    return (slv_tx_q.size() > 0) ? slv_tx_q[0] : 8'h00;
  endfunction

  always @(negedge ss) begin
    s_sh  = slv_peek();
    s_cnt = 0;
  end

  always @(posedge ss) begin
    s_cnt = 0;
    ss_rise_cnt++;
  end

  always @(posedge sck) begin
    sck_rise_cnt++;
    if (ss === 1'b0) begin
      s_rx  = {s_rx[6:0], mosi};
      s_cnt = s_cnt + 1;
      if (s_cnt == 8) begin
        s_cnt = 0;
        if (slv_tx_q.size() > 0) slv_tx_q.delete(0);
        if (exp_mosi_q.size() == 0) chk("slave_rx_extra", exp_mosi_q.size(), 1);
        else chk("slave_rx", s_rx, exp_mosi_q.pop_front());
      end
    end
  end

  always @(negedge sck) begin
    if (ss === 1'b0) begin
      if (s_cnt == 0) s_sh = slv_peek();
      else            s_sh = {s_sh[6:0], 1'b0};
    end
  end

  always @(posedge sck2) sck2_rise_t.push_back($time);

  logic prev_sck = 1'b0, prev_mosi = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_rdata_q.size() == 0) chk("rdata_extra_done", exp_rdata_q.size(), 1);
        else chk("rdata", rdata, exp_rdata_q.pop_front());
      end
      if (ss === 1'b0) chk("busy_with_ss_low", busy, 1);
      if (prev_sck && sck === 1'b1) chk("mosi_stable_sck_high", mosi, prev_mosi);
    end
    prev_sck  = sck;
    prev_mosi = mosi;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("idle_timeout", busy, 0);
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] sx, input logic [7:0] er);
    time t_acc;
    int  n;
    wait_idle();
    slv_tx_q.push_back(sx);
    exp_rdata_q.push_back(er);
    exp_mosi_q.push_back(tx);
    @(negedge clk); start = 1'b1; tdata = tx;
    @(posedge clk); t_acc = $time;
    @(negedge clk); start = 1'b0; tdata = 8'($urandom);
    chk("ss_low_after_start", ss, 0);
    chk("mosi_msb_at_load", mosi, tx[7]);
    n = 0; while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("done_latency", 32'($time - t_acc), 32'(64 * T + 5));
    n = 0; while (ss !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("ss_rise_time", 32'($time - t_acc), 32'(68 * T + 5));
    n = 0; while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("busy_fall_time", 32'($time - t_acc), 32'(72 * T + 5));
  endtask

  task automatic test_burst();
    time t_d1;
    int  n, rises;
    wait_idle();
    slv_tx_q.push_back(8'h42);    slv_tx_q.push_back(8'h99);
    exp_rdata_q.push_back(8'h42); exp_rdata_q.push_back(8'h99);
    exp_mosi_q.push_back(8'h81);  exp_mosi_q.push_back(8'h7E);
    @(negedge clk); start = 1'b1; tdata = 8'h81;
    @(negedge clk); start = 1'b0;
    rises = ss_rise_cnt;
    n = 0; while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    t_d1 = $time;
    start = 1'b1; tdata = 8'h7E;
    @(negedge clk); start = 1'b0; tdata = 8'h00;
    n = 0; while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("burst_done_spacing", 32'($time - t_d1), 32'(65 * T));
    chk("burst_ss_stayed_low", ss_rise_cnt, rises);
  endtask

  task automatic test_ignored_start();
    int n, base;
    wait_idle();
    slv_tx_q.push_back(8'h5A); exp_rdata_q.push_back(8'h5A); exp_mosi_q.push_back(8'h3C);
    base = done_cnt;
    @(negedge clk); start = 1'b1; tdata = 8'h3C;
    @(negedge clk); start = 1'b0; tdata = 8'hFF;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0; while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0; while (ss !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0; while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    repeat (8 * D) @(negedge clk);
    chk("ignored_no_extra_busy", busy, 0);
    chk("ignored_done_count", done_cnt - base, 1);
  endtask

  task automatic test_reset_mid();
    int n, base_done, base_r;
    wait_idle();
    slv_tx_q.push_back(8'h11); exp_rdata_q.push_back(8'h11); exp_mosi_q.push_back(8'hE7);
    base_done = done_cnt;
    base_r    = sck_rise_cnt;
    @(negedge clk); start = 1'b1; tdata = 8'hE7;
    @(negedge clk); start = 1'b0;
    n = 0; while (sck_rise_cnt < base_r + 4 && n < 200) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ss", ss, 1);
    chk("rst_mid_sck", sck, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mosi", mosi, 0);
    chk("rst_mid_rdata", rdata, 0);
    rst = 1'b0;
    slv_tx_q.delete(); exp_rdata_q.delete(); exp_mosi_q.delete();
    repeat (4) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - base_done, 0);
    xfer(8'h55, 8'hC3, 8'hC3);
  endtask

  task automatic test_continuous();
    time t;
    int  n, nd, rises;
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      slv_tx_q.push_back(8'(8'h10 + i));
      exp_rdata_q.push_back(8'(8'h10 + i));
      exp_mosi_q.push_back(8'h96);
    end
    rises = ss_rise_cnt;
    @(negedge clk); start = 1'b1; tdata = 8'h96;
    nd = 0; n = 0;
    while (nd < 2 && n < 400) begin
      @(negedge clk); n++;
      if (done === 1'b1) nd++;
    end
    @(negedge clk); start = 1'b0;
    n = 0; while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("cont_ss_low_all_frames", ss_rise_cnt, rises);
    n = 0; while (ss !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    t = $time;
    n = 0; while (busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    chk("cont_gap_len", 32'($time - t), 32'(D * T));
  endtask

  task automatic test_min_div();
    time t;
    int  n;
    @(negedge clk); start2 = 1'b1; tdata2 = 8'h00;
    @(posedge clk); t = $time;
    @(negedge clk); start2 = 1'b0;
    n = 0; while (done2 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("d2_done_latency", 32'($time - t), 32'(32 * T + 5));
    chk("d2_rdata", rdata2, 8'hFF);
    chk("d2_mosi_lsb", mosi2, 0);
    chk("d2_sck_rises", sck2_rise_t.size(), 8);
    if (sck2_rise_t.size() >= 2)
      chk("d2_sck_period", 32'(sck2_rise_t[1] - sck2_rise_t[0]), 32'(4 * T));
    n = 0; while (ss2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    t = $time;
    n = 0; while (busy2 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    chk("d2_gap_len", 32'($time - t), 32'(2 * T));
  endtask

  initial begin : main
    vec_t vecs[4];
    vecs[0] = '{tx: 8'hA5, slv: 8'h3C, exp_rdata: 8'h3C};
    vecs[1] = '{tx: 8'h00, slv: 8'hFF, exp_rdata: 8'hFF};
    vecs[2] = '{tx: 8'hFF, slv: 8'h00, exp_rdata: 8'h00};
    vecs[3] = '{tx: 8'h69, slv: 8'h81, exp_rdata: 8'h81};

    repeat (3) @(negedge clk);
    chk("reset_ss", ss, 1);
    chk("reset_sck", sck, 0);
    chk("reset_mosi", mosi, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rdata", rdata, 0);
    rst  = 1'b0;
    rst2 = 1'b0;

    for (int i = 0; i < 4; i++) xfer(vecs[i].tx, vecs[i].slv, vecs[i].exp_rdata);
    test_burst();
    test_ignored_start();
    test_reset_mid();
    test_continuous();
    test_min_div();

    repeat (20) @(negedge clk);
    chk("pending_rdata", exp_rdata_q.size(), 0);
    chk("pending_slave_rx", exp_mosi_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/spi_master.md
# spi_master

Single-clock SPI master that generates `sck`, `ss` and `mosi` and captures `miso`. It is the counterpart of the team's `spi_slave`. Mode 0, MSB first, 8-bit frames, with optional back-to-back bursts under one `ss` assertion. It sits between a local controller, which uses a start/busy/done handshake, and the off-chip or on-chip SPI slave pins.

## Interface
- `CLK_DIV`, default 4: `sck` half-period in `clk` cycles. Legal range ≥ 2.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: transfer request. Sampled only in IDLE or in the done cycle.
- `tdata` input 8: byte to transmit. Captured at the edge that accepts `start`.
- `busy` output 1: high from acceptance until the end of GAP.
- `done` output 1: one-cycle pulse; `rdata` is valid from this cycle on.
- `rdata` output 8: last received byte. Holds its value until the next `done`.
- `ss` output 1: slave select, active low.
- `sck` output 1: serial clock. Idles low.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.

## Operation
- **States:** IDLE, SETUP, SHIFT, HOLD, GAP.
- **Divider:** counter `div_cnt` counts 0..CLK_DIV-1. Every phase (SETUP, each `sck` half, HOLD, GAP) lasts exactly CLK_DIV cycles.
- **IDLE:** `ss`=1, `sck`=0, `busy`=0.
  - `start`=1 at an edge: latch `tdata` into `tx_sh`; `ss`←0, `mosi`←`tdata[7]`, `busy`←1; go to SETUP.
- **SETUP:** `sck` stays low for CLK_DIV cycles, then `sck`←1 and go to SHIFT.
- **SHIFT:**
  - At every edge that drives `sck` 0→1: `rx_sh` ← {`rx_sh[6:0]`, `miso`}. `miso` is sampled directly, with no synchronizer, because `sck` is master-generated.
  - At every edge that drives `sck` 1→0: bit counter +1. If fewer than 8 bits are done, `mosi` ← next `tx_sh` bit (MSB first).
  - At the 8th 1→0 edge: `rdata` ← `rx_sh`, `done`←1, go to HOLD.
- **HOLD:**
  - The first HOLD cycle is the done cycle.
  - If `start`=1 in the done cycle (burst): latch the new `tdata`, `mosi`←`tdata[7]`, keep `ss`=0, clear the bit counter, go to SETUP.
  - Otherwise: `ss` stays 0 for the rest of the CLK_DIV cycles, then `ss`←1 and go to GAP.
- **GAP:** `ss`=1 for CLK_DIV cycles, then `busy`←0 and go to IDLE. This guarantees the minimum `ss`-high time so the slave resets its bit counters.
- **Ignored `start`:** `start` in SETUP, SHIFT, GAP, or in a HOLD cycle other than the done cycle, is ignored. `tdata` changes outside the acceptance edge have no effect.
- **`mosi` after the last bit:** after the 8th bit `mosi` holds the LSB until the next load.
- **Reset (any state, including mid-transfer):**
  - Next edge: `ss`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `rdata`=8'h00. All counters and shift registers clear; state goes to IDLE.
  - No `done` is issued for an aborted frame.
- **`done` and `busy`:** `done` never asserts outside the cycle after an 8th falling `sck` edge. `busy`=1 whenever `ss`=0.

## Timing
Notation: E0 is the edge accepting `start`; D = CLK_DIV.

- **Frame:**
  - E1: `ss`=0, `mosi`=MSB.
  - Rise k at E1+(2k-1)·D; fall k at E1+2k·D.
  - `done`=1 in the cycle after E1+16D.
  - `ss`=1 at E1+17D.
  - `busy`=0 at E1+18D.
- **Example, D=4:** `ss` low at E1, `done` after E65, `ss` high at E69, `busy` low at E73.
- **Burst:**
  - The next byte's first rise occurs D cycles after the done-cycle edge.
  - `ss` remains low throughout.
  - Throughput is 16D+1 cycles per byte.
- **Latencies:**
  - `start` → `ss` low: 1 cycle.
  - `rdata` update coincides with `done`.
- **Output stability:** `sck` duty cycle is exactly 50%. `mosi` changes only together with a falling `sck` or at a load; it never changes while `sck`=1.

## Test plan
- **Single byte:** D=4, `tdata`=8'hA5, slave model returns 8'h3C → `rdata`=8'h3C at `done` (cycle after E1+64). Slave receives 8'hA5. `ss` rises at E1+68. `busy` falls at E1+72.
- **Burst:** `tdata` 8'h81, then 8'h7E with `start` high in the done cycle → `ss` never rises between bytes. Slave receives 81, 7E. Two `done` pulses 65 cycles apart.
- **Ignored start:** `start` pulsed in SHIFT and in GAP with `tdata`=8'hFF → no extra frame. The current frame's `mosi` bits are unchanged.
- **Reset mid-transfer:** `rst` at the 4th rising `sck` → next edge `ss`=1, `sck`=0, `busy`=0. No `done`. A following `start` with 8'h55 completes normally with `rdata` from the slave.
- **Minimum divider:** D=2, `tdata`=8'h00, `miso` tied 1 → `rdata`=8'hFF after 33 cycles. `sck` period is 4 cycles. GAP is 2 cycles.
- **Continuous `start`:** `start` held high for 3 frames → 3 back-to-back bytes under one `ss`. The `ss`-high gap is ≥ D after the last byte.
